// File: rtl/tmr_vote_sequencer_if.sv
// Handshake and status bundle for tmr_vote_sequencer.
// The slave modport is the sequencer; the master modport is the channel/consumer side.
interface tmr_vote_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [2:0]       in_valid;
    logic [2:0]       in_ready;
    logic [WIDTH-1:0] in_data_a;
    logic [WIDTH-1:0] in_data_b;
    logic [WIDTH-1:0] in_data_c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_degraded;
    logic [2:0]       mismatch;
    logic             timeout_err;
    logic             vote_err;
    logic [2:0]       fault;
    logic             clear_fault;

    modport master (
        output in_valid, in_data_a, in_data_b, in_data_c, out_ready, clear_fault,
        input  in_ready, out_valid, out_data, out_degraded, mismatch,
               timeout_err, vote_err, fault
    );

    modport slave (
        input  in_valid, in_data_a, in_data_b, in_data_c, out_ready, clear_fault,
        output in_ready, out_valid, out_data, out_degraded, mismatch,
               timeout_err, vote_err, fault
    );
endinterface

// File: rtl/tmr_vote_sequencer.sv
// Collects one word per redundant channel A/B/C, majority-votes them and tracks channel faults.
// Build macro TMR_FAULT_MASK_EN: channels with a set fault flag are sunk and excluded from the vote.
module tmr_vote_sequencer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned TIMEOUT   = 15,
    parameter int unsigned ERR_LIMIT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    tmr_vote_sequencer_if.slave bus
);
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);
    localparam int unsigned CWR = $clog2(ERR_LIMIT + 1);
    localparam int unsigned CW  = (CWR < 2) ? 2 : CWR;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VOTE, S_HOLD} state_e;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

    state_e           state_q, state_d;
    logic [2:0]       captured_q, captured_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [WIDTH-1:0] word_q [3];
    logic [WIDTH-1:0] word_d [3];
    logic             vote_degr_q, vote_degr_d;
    logic [CW-1:0]    err_cnt_q [3];
    logic [CW-1:0]    err_cnt_d [3];

    logic [2:0]       in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_degraded_q, out_degraded_d;
    logic [2:0]       mismatch_q, mismatch_d;
    logic             timeout_err_q, timeout_err_d;
    logic             vote_err_q, vote_err_d;
    logic [2:0]       fault_q, fault_d;

    logic [2:0]       mask_c, mask_d;
    logic [2:0]       acc_c, cap_nx_c;
    logic [1:0]       n_cap_c;
    logic             collecting_c, complete_c, expired_c, resolve_c;
    logic             pair_eq_c, go_vote_c;
    logic [WIDTH-1:0] vote_c;

`ifdef TMR_FAULT_MASK_EN
    assign mask_c = fault_q;
    assign mask_d = fault_d;
`else
    assign mask_c = 3'b000;
    assign mask_d = 3'b000;
`endif

    // Set resolution: a set closes when every unmasked channel is in, or on timeout.
    assign collecting_c = (state_q == S_IDLE) || (state_q == S_COLLECT);
    assign acc_c        = bus.in_valid & in_ready_q & ~mask_c;
    assign cap_nx_c     = captured_q | acc_c;
    assign n_cap_c      = popcount3(cap_nx_c);
    assign complete_c   = ((cap_nx_c | mask_c) == 3'b111) && (popcount3(mask_c) < 2'd2);
    assign expired_c    = (state_q == S_COLLECT) && (timer_q == TW'(TIMEOUT));
    assign resolve_c    = collecting_c && ((|acc_c) || (state_q == S_COLLECT))
                          && (complete_c || expired_c);
    assign go_vote_c    = resolve_c && ((n_cap_c == 2'd3) || ((n_cap_c == 2'd2) && pair_eq_c));
    assign vote_c       = (word_q[0] & word_q[1]) | (word_q[1] & word_q[2]) | (word_q[0] & word_q[2]);

    always_comb begin
        for (int i = 0; i < 3; i++) word_d[i] = word_q[i];
        if (acc_c[0]) word_d[0] = bus.in_data_a;
        if (acc_c[1]) word_d[1] = bus.in_data_b;
        if (acc_c[2]) word_d[2] = bus.in_data_c;
    end

    always_comb begin
        pair_eq_c = 1'b0;
        case (cap_nx_c)
            3'b011:  pair_eq_c = (word_d[0] == word_d[1]);
            3'b101:  pair_eq_c = (word_d[0] == word_d[2]);
            3'b110:  pair_eq_c = (word_d[1] == word_d[2]);
            default: pair_eq_c = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (resolve_c)   state_d = go_vote_c ? S_VOTE : S_IDLE;
                else if (|acc_c) state_d = S_COLLECT;
            end
            S_COLLECT: if (resolve_c) state_d = go_vote_c ? S_VOTE : S_IDLE;
            S_VOTE:    state_d = S_HOLD;
            S_HOLD:    if (bus.out_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_comb begin
        captured_d     = 3'b000;
        timer_d        = '0;
        vote_degr_d    = vote_degr_q;
        out_data_d     = out_data_q;
        out_degraded_d = out_degraded_q;
        mismatch_d     = mismatch_q;
        fault_d        = fault_q;
        for (int i = 0; i < 3; i++) err_cnt_d[i] = err_cnt_q[i];
        timeout_err_d  = resolve_c && (n_cap_c < 2'd2);
        vote_err_d     = resolve_c && (n_cap_c == 2'd2) && !pair_eq_c;
        out_valid_d    = (state_d == S_HOLD);

        if (collecting_c) begin
            captured_d  = (state_d == S_IDLE) ? 3'b000 : cap_nx_c;
            vote_degr_d = (n_cap_c != 2'd3);
            if ((state_q == S_COLLECT) && (state_d == S_COLLECT)) timer_d = timer_q + TW'(1);
        end

        if (state_q == S_VOTE) begin
            if (vote_degr_q) begin
                out_data_d     = captured_q[0] ? word_q[0] : word_q[1];
                out_degraded_d = 1'b1;
                mismatch_d     = ~captured_q;
            end else begin
                out_data_d     = vote_c;
                out_degraded_d = 1'b0;
                for (int i = 0; i < 3; i++) mismatch_d[i] = (word_q[i] != vote_c);
            end
            for (int i = 0; i < 3; i++) begin
                if (!mismatch_d[i])                        err_cnt_d[i] = '0;
                else if (err_cnt_q[i] < CW'(ERR_LIMIT))    err_cnt_d[i] = err_cnt_q[i] + CW'(1);
                if (err_cnt_d[i] == CW'(ERR_LIMIT))        fault_d[i]   = 1'b1;
            end
        end

        // A clear in the same cycle as an increment takes priority.
        if (bus.clear_fault) begin
            fault_d = 3'b000;
            for (int i = 0; i < 3; i++) err_cnt_d[i] = '0;
        end

        case (state_d)
            S_IDLE:    in_ready_d = 3'b111;
            S_COLLECT: in_ready_d = ~captured_d | mask_d;
            default:   in_ready_d = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            captured_q     <= 3'b000;
            timer_q        <= '0;
            vote_degr_q    <= 1'b0;
            in_ready_q     <= 3'b111;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_degraded_q <= 1'b0;
            mismatch_q     <= 3'b000;
            timeout_err_q  <= 1'b0;
            vote_err_q     <= 1'b0;
            fault_q        <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                word_q[i]    <= '0;
                err_cnt_q[i] <= '0;
            end
        end else begin
            captured_q     <= captured_d;
            timer_q        <= timer_d;
            vote_degr_q    <= vote_degr_d;
            in_ready_q     <= in_ready_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_degraded_q <= out_degraded_d;
            mismatch_q     <= mismatch_d;
            timeout_err_q  <= timeout_err_d;
            vote_err_q     <= vote_err_d;
            fault_q        <= fault_d;
            for (int i = 0; i < 3; i++) begin
                word_q[i]    <= word_d[i];
                err_cnt_q[i] <= err_cnt_d[i];
            end
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_degraded = out_degraded_q;
    assign bus.mismatch     = mismatch_q;
    assign bus.timeout_err  = timeout_err_q;
    assign bus.vote_err     = vote_err_q;
    assign bus.fault        = fault_q;
endmodule

// File: tb/tb_tmr_vote_sequencer.sv
// Scoreboard bench for tmr_vote_sequencer: stimulus pushes expected results, a monitor pops on each output handshake.
module tb_tmr_vote_sequencer;
    localparam int unsigned TIMEOUT = 15;

    typedef struct {
        logic [7:0] data;
        logic       deg;
        logic [2:0] mm;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_to   = 0;
    int   n_ve   = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    tmr_vote_sequencer_if #(.WIDTH(8)) bus ();

    tmr_vote_sequencer #(.WIDTH(8), .TIMEOUT(TIMEOUT), .ERR_LIMIT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] v, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c);
        bus.in_valid  = v;
        bus.in_data_a = a;
        bus.in_data_b = b;
        bus.in_data_c = c;
        cyc();
        bus.in_valid  = 3'b000;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(bus.in_ready == 3'b111 && !bus.out_valid) && n < 100) begin
            cyc();
            n++;
        end
        if (n >= 100) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_idle: no return to IDLE within 100 cycles");
        end
    endtask

    // Monitor: counts error pulses and checks every accepted output against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.timeout_err) n_to++;
            if (bus.vote_err)    n_ve++;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out: got data 0x%0h with empty scoreboard", bus.out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_data",     32'(bus.out_data),     32'(mon_e.data));
                    check("sb_degraded", 32'(bus.out_degraded), 32'(mon_e.deg));
                    check("sb_mismatch", 32'(bus.mismatch),     32'(mon_e.mm));
                end
            end
        end
    end

    initial begin
        int to0;
        int ve0;
        int w;
        logic [2:0] exp_f;

        rst_n           = 1'b0;
        bus.in_valid    = 3'b000;
        bus.in_data_a   = 8'h00;
        bus.in_data_b   = 8'h00;
        bus.in_data_c   = 8'h00;
        bus.out_ready   = 1'b1;
        bus.clear_fault = 1'b0;
        repeat (3) cyc();
        check("rst_in_ready",  32'(bus.in_ready),     32'(3'b111));
        check("rst_out_valid", 32'(bus.out_valid),    32'(1'b0));
        check("rst_out_data",  32'(bus.out_data),     32'(8'h00));
        check("rst_degraded",  32'(bus.out_degraded), 32'(1'b0));
        check("rst_mismatch",  32'(bus.mismatch),     32'(3'b000));
        check("rst_fault",     32'(bus.fault),        32'(3'b000));
        check("rst_timeout",   32'(bus.timeout_err),  32'(1'b0));
        check("rst_vote_err",  32'(bus.vote_err),     32'(1'b0));
        rst_n = 1'b1;
        cyc();

        // All three in one IDLE cycle: out_valid two cycles after capture.
        exp_q.push_back('{8'h5A, 1'b0, 3'b000});
        send(3'b111, 8'h5A, 8'h5A, 8'h5A);
        check("t1_lat_plus1", 32'(bus.out_valid), 32'(1'b0));
        cyc();
        check("t1_lat_plus2", 32'(bus.out_valid), 32'(1'b1));
        wait_idle();

        // Staggered arrivals, every channel disagrees with the vote.
        exp_q.push_back('{8'hE8, 1'b0, 3'b111});
        send(3'b001, 8'hF0, 8'h00, 8'h00);
        check("t2_ready_after_a", 32'(bus.in_ready), 32'(3'b110));
        send(3'b010, 8'h00, 8'hCC, 8'h00);
        send(3'b100, 8'h00, 8'h00, 8'hAA);
        wait_idle();

        // C missing, A==B: degraded vote after the timeout.
        exp_q.push_back('{8'h11, 1'b1, 3'b100});
        send(3'b011, 8'h11, 8'h11, 8'h00);
        repeat (TIMEOUT + 1) cyc();
        check("t3_not_early", 32'(bus.out_valid), 32'(1'b0));
        cyc();
        check("t3_valid", 32'(bus.out_valid), 32'(1'b1));
        wait_idle();

        // Two disagreeing words, then a single word.
        to0 = n_to;
        ve0 = n_ve;
        send(3'b011, 8'h11, 8'h22, 8'h00);
        repeat (TIMEOUT + 5) cyc();
        check("t4_vote_err_pulses", 32'(n_ve - ve0), 32'd1);
        check("t4_no_timeout",      32'(n_to - to0), 32'd0);
        send(3'b001, 8'h11, 8'h00, 8'h00);
        repeat (TIMEOUT + 5) cyc();
        check("t4_timeout_pulses", 32'(n_to - to0), 32'd1);
        check("t4_vote_err_same",  32'(n_ve - ve0), 32'd1);

        // Clean set clears counters, then C disagrees three times running.
        exp_q.push_back('{8'h33, 1'b0, 3'b000});
        send(3'b111, 8'h33, 8'h33, 8'h33);
        wait_idle();
        check("t5_fault_start", 32'(bus.fault), 32'(3'b000));
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back('{8'h0F, 1'b0, 3'b100});
            send(3'b111, 8'h0F, 8'h0F, 8'hF0);
            wait_idle();
            exp_f = (k == 3) ? 3'b100 : 3'b000;
            check("t5_fault_seq", 32'(bus.fault), 32'(exp_f));
        end
        exp_q.push_back('{8'h33, 1'b0, 3'b000});
        send(3'b111, 8'h33, 8'h33, 8'h33);
        wait_idle();
        check("t5_fault_sticky", 32'(bus.fault), 32'(3'b100));
        bus.clear_fault = 1'b1;
        cyc();
        bus.clear_fault = 1'b0;
        check("t5_fault_cleared", 32'(bus.fault), 32'(3'b000));

        // Back-pressure in HOLD.
        bus.out_ready = 1'b0;
        exp_q.push_back('{8'h77, 1'b0, 3'b100});
        send(3'b111, 8'h77, 8'h77, 8'h78);
        w = 0;
        while (!bus.out_valid && w < 30) begin
            cyc();
            w++;
        end
        for (int i = 0; i < 10; i++) begin
            check("t6_hold_valid", 32'(bus.out_valid), 32'(1'b1));
            check("t6_hold_data",  32'(bus.out_data),  32'(8'h77));
            check("t6_hold_ready", 32'(bus.in_ready),  32'(3'b000));
            cyc();
        end
        bus.out_ready = 1'b1;
        wait_idle();
        check("t6_mismatch_holds", 32'(bus.mismatch), 32'(3'b100));

        // Asynchronous reset in the middle of a set.
        send(3'b001, 8'h44, 8'h00, 8'h00);
        cyc();
        check("t6_mid_collect_ready", 32'(bus.in_ready), 32'(3'b110));
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_in_ready",  32'(bus.in_ready),     32'(3'b111));
        check("t6_rst_out_valid", 32'(bus.out_valid),    32'(1'b0));
        check("t6_rst_out_data",  32'(bus.out_data),     32'(8'h00));
        check("t6_rst_mismatch",  32'(bus.mismatch),     32'(3'b000));
        check("t6_rst_degraded",  32'(bus.out_degraded), 32'(1'b0));
        repeat (2) cyc();
        rst_n = 1'b1;
        to0 = n_to;
        repeat (TIMEOUT + 5) cyc();
        check("t6_set_discarded", 32'(n_to - to0),  32'd0);
        check("t6_idle_ready",    32'(bus.in_ready), 32'(3'b111));

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
